btn_word_tx: RTL
================

BTN_WORD_TX -- requirements
Module: btn_word_tx

Interface
REQ-001 SHALL have parameter DATA_LEN, default 48: number of data bits per frame, range 2..64.
REQ-002 SHALL have parameter GAP, default 0: idle cycles inserted after every bit pulse, range 0..255.
REQ-003 SHALL have port clk  input  1  single clock; all logic is on its rising edge.
REQ-004 SHALL have port ck_rstn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port s_data  input  DATA_LEN  parallel word to transmit, MSB first.
REQ-006 SHALL have port s_valid  input  1  word offer.
REQ-007 SHALL have port s_ready  output  1  block can accept a word.
REQ-008 SHALL have port abort_i  input  1  synchronous frame abort.
REQ-009 SHALL have port bit0_o  output  1  one-cycle strobe meaning data bit '0'.
REQ-010 SHALL have port bit1_o  output  1  one-cycle strobe meaning data bit '1'.
REQ-011 SHALL have port commit_o  output  1  one-cycle end-of-frame strobe.
REQ-012 SHALL have port busy_o  output  1  frame in progress.

Function
REQ-013 SHALL implement the FSM states IDLE, BIT, GAP and COMMIT.
REQ-014 SHALL drive s_ready high only in IDLE; a transfer occurs when s_valid and s_ready are both high at a rising edge; s_data is captured into a shift register on that edge and later changes are ignored.
REQ-015 SHALL, for an accept at edge T, emit bit pulse k (k=0 is the MSB) in cycle T+1+k*(GAP+1).
REQ-016 SHALL assert exactly one of bit0_o/bit1_o in each BIT cycle; both SHALL be low in every other state.
REQ-017 SHALL, after the final bit pulse, spend GAP idle cycles and then assert commit_o for one cycle at T+1+N*(GAP+1), where N is the number of bits sent.
REQ-018 SHALL return to IDLE the cycle after COMMIT, with s_ready high at T+2+N*(GAP+1); back-to-back frames are allowed with no extra idle cycle.
REQ-019 SHALL skip the GAP state entirely when GAP=0 (BIT->BIT, last BIT->COMMIT).
REQ-020 SHALL hold busy_o high in BIT, GAP and COMMIT, and low in IDLE.
REQ-021 SHALL, when abort_i is high at any edge outside IDLE, enter IDLE on that edge; no further bit pulses or commit_o occur and the shift register is cleared.
REQ-022 SHALL give abort_i priority over acceptance, so that abort_i high in IDLE blocks the transfer (s_ready forced low).
REQ-023 SHALL use a bit counter of width $clog2(DATA_LEN+2) and a gap counter of width 8; neither counter wraps during a frame.

Reset
REQ-024 SHALL, while ck_rstn is low, asynchronously force: state IDLE, s_ready 0, bit0_o/bit1_o/commit_o/busy_o 0, counters and shift register 0.
REQ-025 SHALL raise s_ready on the first clk edge after ck_rstn deasserts; a frame interrupted by reset is discarded with no commit_o.

Configuration
REQ-026 SHALL, when macro BTN_WORD_TX_PARITY_EN is defined, append one even-parity bit (XOR of all data bits) after the LSB as an extra bit pulse, so N=DATA_LEN+1.
REQ-027 SHALL, without the macro, send no parity bit (N=DATA_LEN) and contain no parity logic.

Structure
REQ-028 SHALL place the FSM state enum, the default DATA_LEN constant (48) and the GAP counter width (8) in the shared package btn_word_pkg.
REQ-029 SHALL implement the gap counter as one sub-module, btn_gap_cnt: load, decrement, and a zero flag.

Verification
REQ-030 SHALL cover: GAP=0, s_data=48'hFF_FF_FF_FF_FF_00 accepted at T -> bit1_o in T+1..T+40, bit0_o in T+41..T+48, commit_o at T+49, s_ready at T+50.
REQ-031 SHALL cover: GAP=3, DATA_LEN=8, s_data=8'hA5 -> pulses 1,0,1,0,0,1,0,1 at T+1, T+5, ..., T+29; commit_o at T+33.
REQ-032 SHALL cover: abort_i high in the cycle of bit 10 -> that bit and all later pulses suppressed, no commit_o, s_ready high on the next edge.
REQ-033 SHALL cover: ck_rstn low mid-frame -> all outputs 0 immediately (asynchronously); after release, a new frame 48'h0 produces 48 bit0_o pulses and commit_o.
REQ-034 SHALL cover, with BTN_WORD_TX_PARITY_EN and DATA_LEN=8: s_data=8'h07 -> 9th pulse is bit1_o; commit_o at T+10.
REQ-035 SHALL cover: s_valid held high for two frames -> second accept in the cycle after commit_o; bit0_o&bit1_o never high together.

Source files
------------

// File: rtl/btn_word_pkg.sv
// Shared types and constants for the bit-pulse word transmitter.
package btn_word_pkg;

  localparam int DATA_LEN_DEF = 48;
  localparam int GAP_CNT_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BIT,
    ST_GAP,
    ST_COMMIT
  } state_t;

endpackage

// File: rtl/btn_gap_cnt.sv
// Idle-gap down counter: load, decrement (saturating at zero), zero flag.
module btn_gap_cnt
  import btn_word_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 load,
  input  logic [GAP_CNT_W-1:0] load_val,
  input  logic                 dec,
  output logic                 zero
);

  logic [GAP_CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (load)               cnt <= load_val;
    else if (dec && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/btn_word_tx.sv
// Serialises a parallel word MSB-first as one-cycle bit0/bit1 strobes, then commit.
// Optional even-parity trailer bit when BTN_WORD_TX_PARITY_EN is defined.
module btn_word_tx
  import btn_word_pkg::*;
#(
  parameter int DATA_LEN = DATA_LEN_DEF,
  parameter int GAP      = 0
) (
  input  logic                clk,
  input  logic                ck_rstn,
  input  logic [DATA_LEN-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic                abort_i,
  output logic                bit0_o,
  output logic                bit1_o,
  output logic                commit_o,
  output logic                busy_o
);

`ifdef BTN_WORD_TX_PARITY_EN
  localparam int N = DATA_LEN + 1;
`else
  localparam int N = DATA_LEN;
`endif
  localparam int BCW = $clog2(DATA_LEN + 2);
  localparam bit HAS_GAP = (GAP > 0);
  localparam logic [GAP_CNT_W-1:0] GAP_LD = HAS_GAP ? GAP_CNT_W'(GAP - 1) : '0;

  state_t         state;
  logic [N-1:0]   sh;
  logic [N-1:0]   frame;
  logic [BCW-1:0] bit_cnt;
  logic           rdy_q, b0_q, b1_q, cmt_q;
  logic           gap_zero, last;

`ifdef BTN_WORD_TX_PARITY_EN
  assign frame = {s_data, ^s_data};
`else
  assign frame = s_data;
`endif

  assign last = (bit_cnt == BCW'(N));

  btn_gap_cnt u_gap (
    .clk      (clk),
    .rst_n    (ck_rstn),
    .clr      (abort_i),
    .load     (state == ST_BIT),
    .load_val (GAP_LD),
    .dec      (state == ST_GAP),
    .zero     (gap_zero)
  );

  always_ff @(posedge clk or negedge ck_rstn) begin
    if (!ck_rstn) begin
      state   <= ST_IDLE;
      rdy_q   <= 1'b0;
      b0_q    <= 1'b0;
      b1_q    <= 1'b0;
      cmt_q   <= 1'b0;
      sh      <= '0;
      bit_cnt <= '0;
    end else begin
      b0_q  <= 1'b0;
      b1_q  <= 1'b0;
      cmt_q <= 1'b0;
      if (abort_i && state != ST_IDLE) begin
        state   <= ST_IDLE;
        rdy_q   <= 1'b1;
        sh      <= '0;
        bit_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            rdy_q <= 1'b1;
            if (s_valid && s_ready) begin
              // First pulse goes out straight from the captured word.
              state   <= ST_BIT;
              rdy_q   <= 1'b0;
              b1_q    <= frame[N-1];
              b0_q    <= ~frame[N-1];
              sh      <= frame << 1;
              bit_cnt <= BCW'(1);
            end
          end
          ST_BIT: begin
            if (HAS_GAP) begin
              state <= ST_GAP;
            end else if (last) begin
              state <= ST_COMMIT;
              cmt_q <= 1'b1;
            end else begin
              b1_q    <= sh[N-1];
              b0_q    <= ~sh[N-1];
              sh      <= sh << 1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          ST_GAP: begin
            if (gap_zero) begin
              if (last) begin
                state <= ST_COMMIT;
                cmt_q <= 1'b1;
              end else begin
                state   <= ST_BIT;
                b1_q    <= sh[N-1];
                b0_q    <= ~sh[N-1];
                sh      <= sh << 1;
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          ST_COMMIT: begin
            state   <= ST_IDLE;
            rdy_q   <= 1'b1;
            bit_cnt <= '0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // abort_i masks strobes in the very cycle it is seen, so the current pulse is suppressed too.
  assign s_ready  = rdy_q & ~abort_i;
  assign bit0_o   = b0_q & ~abort_i;
  assign bit1_o   = b1_q & ~abort_i;
  assign commit_o = cmt_q & ~abort_i;
  assign busy_o   = (state != ST_IDLE);

endmodule
